// File: rtl/fpww_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fpww_pkg
// Description : Shared types and constants for the FPWW wristwatch
//               time-of-day core: mode encoding, field limits and widths.
// Revision    : 1.0 - initial release
// ============================================================================
package fpww_pkg;

    localparam int HR_W        = 5;
    localparam int MIN_SEC_W   = 6;
    localparam int PRESC_W     = 10;
    localparam int MAX_HR      = 23;
    localparam int MAX_SEC_MIN = 59;

    // 2'b11 is not a legal mode; the FSM recovers from it to MODE_RUN.
    typedef enum logic [1:0] {
        MODE_RUN     = 2'd0,
        MODE_SET_HR  = 2'd1,
        MODE_SET_MIN = 2'd2,
        MODE_ILLEGAL = 2'd3
    } mode_e;

endpackage : fpww_pkg
`default_nettype wire

// File: rtl/mod_n_counter.sv
`default_nettype none
// ============================================================================
// Module      : mod_n_counter
// Description : Modulo-(MAX+1) up counter with synchronous clear and a
//               wrap flag that fires in the cycle the counter rolls to zero.
// Ports       : clk, rst_n     - clock, asynchronous active-low reset
//               inc            - advance by one this cycle
//               clear          - force to zero (has priority over inc)
//               value          - current count, 0..MAX
//               wrap           - inc while value == MAX (carry out)
// Revision    : 1.0 - initial release
// ============================================================================
module mod_n_counter #(
    parameter int MAX   = 59,
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clear,
    output logic [WIDTH-1:0] value,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    logic [WIDTH-1:0] value_q;
    logic [WIDTH-1:0] value_d;

    assign wrap  = inc & (value_q == MAX_V);
    assign value = value_q;

    always_comb begin
        value_d = value_q;
        if (clear) begin
            value_d = '0;
        end else if (inc) begin
            value_d = wrap ? '0 : value_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

endmodule : mod_n_counter
`default_nettype wire

// File: rtl/watch_timekeeper.sv
`default_nettype none
// ============================================================================
// Module      : watch_timekeeper
// Description : Time-of-day core. Counts seconds from divided tick edges,
//               keeps hh:mm:ss in binary and lets the user stop the clock
//               and set hours / minutes through a three-state mode machine.
// Ports       : clk_27Mhz, rst_n      - clock, asynchronous active-low reset
//               tick_in               - divided tick level (same clock domain)
//               btn_mode, btn_set     - one-cycle debounced button pulses
//               hours/minutes/seconds - binary time fields
//               mode                  - 0 RUN, 1 SET_HR, 2 SET_MIN
//               blink                 - display enable for the edited field
//               sec_pulse             - one cycle per seconds increment
// Revision    : 1.0 - initial release
// ============================================================================
module watch_timekeeper
    import fpww_pkg::*;
#(
    parameter int TICKS_PER_SEC = 1
) (
    input  logic       clk_27Mhz,
    input  logic       rst_n,
    input  logic       tick_in,
    input  logic       btn_mode,
    input  logic       btn_set,
    output logic [4:0] hours,
    output logic [5:0] minutes,
    output logic [5:0] seconds,
    output logic [1:0] mode,
    output logic       blink,
    output logic       sec_pulse
);

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICKS_PER_SEC - 1);

    mode_e              mode_q, mode_d;
    logic               tick_d_q;
    logic               tick_arm_q;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic               blink_q, blink_d;
    logic               sec_pulse_q, sec_pulse_d;

    logic               tick_edge;
    logic               sec_evt;
    logic               is_run, is_set_hr, is_set_min, leave_set_min;
    logic               sec_inc, min_inc, hr_inc;
    logic               sec_wrap, min_wrap, hr_wrap_unused;

    // tick_arm_q stays low after reset until tick_in has been seen low, so a
    // tick_in held high across reset release is not taken as a rising edge.
    assign tick_edge = tick_in & ~tick_d_q & tick_arm_q;
    assign sec_evt   = tick_edge & (presc_q == PRESC_LAST);

    // ---------------- Mode FSM: state register ----------------
    always_ff @(posedge clk_27Mhz or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= MODE_RUN;
        end else begin
            mode_q <= mode_d;
        end
    end

    // ---------------- Mode FSM: next state ----------------
    always_comb begin
        mode_d = mode_q;
        case (mode_q)
            MODE_RUN:     if (btn_mode) mode_d = MODE_SET_HR;
            MODE_SET_HR:  if (btn_mode) mode_d = MODE_SET_MIN;
            MODE_SET_MIN: if (btn_mode) mode_d = MODE_RUN;
            default:      mode_d = MODE_RUN;
        endcase
    end

    // ---------------- Mode FSM: output decode ----------------
    always_comb begin
        is_run        = (mode_q == MODE_RUN);
        is_set_hr     = (mode_q == MODE_SET_HR);
        is_set_min    = (mode_q == MODE_SET_MIN);
        leave_set_min = is_set_min & btn_mode;
    end

    // ---------------- Prescaler, blink, sec_pulse ----------------
    always_comb begin
        presc_d = presc_q;
        if (leave_set_min) begin
            presc_d = '0;
        end else if (tick_edge) begin
            presc_d = sec_evt ? '0 : presc_q + 1'b1;
        end

        blink_d = blink_q;
        if (mode_d != mode_q) begin
            blink_d = 1'b1;
        end else if ((is_set_hr | is_set_min) & sec_evt) begin
            blink_d = ~blink_q;
        end else if (is_run) begin
            blink_d = 1'b1;
        end

        // Decided from the pre-transition mode: a second that lands on the
        // RUN -> SET_HR press still counts.
        sec_pulse_d = is_run & sec_evt;
    end

    always_ff @(posedge clk_27Mhz or negedge rst_n) begin
        if (!rst_n) begin
            tick_d_q    <= 1'b0;
            tick_arm_q  <= 1'b0;
            presc_q     <= '0;
            blink_q     <= 1'b1;
            sec_pulse_q <= 1'b0;
        end else begin
            tick_d_q    <= tick_in;
            tick_arm_q  <= tick_arm_q | ~tick_in;
            presc_q     <= presc_d;
            blink_q     <= blink_d;
            sec_pulse_q <= sec_pulse_d;
        end
    end

    // ---------------- Time fields ----------------
    // In RUN the fields chain through carries; in the set states btn_set
    // drives the selected field alone (dropped if btn_mode is also high).
    assign sec_inc = is_run & sec_evt;
    assign min_inc = is_run ? sec_wrap : (is_set_min & btn_set & ~btn_mode);
    assign hr_inc  = is_run ? min_wrap : (is_set_hr  & btn_set & ~btn_mode);

    mod_n_counter #(.MAX(MAX_SEC_MIN), .WIDTH(MIN_SEC_W)) u_sec (
        .clk   (clk_27Mhz),
        .rst_n (rst_n),
        .inc   (sec_inc),
        .clear (leave_set_min),
        .value (seconds),
        .wrap  (sec_wrap)
    );

    mod_n_counter #(.MAX(MAX_SEC_MIN), .WIDTH(MIN_SEC_W)) u_min (
        .clk   (clk_27Mhz),
        .rst_n (rst_n),
        .inc   (min_inc),
        .clear (1'b0),
        .value (minutes),
        .wrap  (min_wrap)
    );

    mod_n_counter #(.MAX(MAX_HR), .WIDTH(HR_W)) u_hr (
        .clk   (clk_27Mhz),
        .rst_n (rst_n),
        .inc   (hr_inc),
        .clear (1'b0),
        .value (hours),
        .wrap  (hr_wrap_unused)
    );

    assign mode      = mode_q;
    assign blink     = blink_q;
    assign sec_pulse = sec_pulse_q;

endmodule : watch_timekeeper
`default_nettype wire

// File: tb/tb_watch_timekeeper.sv
`default_nettype none
// ============================================================================
// Module      : tb_watch_timekeeper
// Description : Self-checking bench for watch_timekeeper. A vector table
//               covers run/set/blink behaviour; directed sequences cover
//               rollover, set flow, simultaneous events, reset corners and
//               a TICKS_PER_SEC = 4 instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_watch_timekeeper;

    typedef struct {
        logic       tick;
        logic       bm;
        logic       bs;
        logic [4:0] h;
        logic [5:0] m;
        logic [5:0] s;
        logic [1:0] md;
        logic       bl;
        logic       sp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0;
    logic       bmode = 1'b0;
    logic       bset = 1'b0;
    logic       tick_b = 1'b0;
    logic       zero_b = 1'b0;

    logic [4:0] hours, hours_b;
    logic [5:0] minutes, minutes_b, seconds, seconds_b;
    logic [1:0] mode, mode_b;
    logic       blink, blink_b, sec_pulse, sec_pulse_b;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    watch_timekeeper #(.TICKS_PER_SEC(1)) dut (
        .clk_27Mhz (clk),
        .rst_n     (rst_n),
        .tick_in   (tick),
        .btn_mode  (bmode),
        .btn_set   (bset),
        .hours     (hours),
        .minutes   (minutes),
        .seconds   (seconds),
        .mode      (mode),
        .blink     (blink),
        .sec_pulse (sec_pulse)
    );

    watch_timekeeper #(.TICKS_PER_SEC(4)) dut_b (
        .clk_27Mhz (clk),
        .rst_n     (rst_n),
        .tick_in   (tick_b),
        .btn_mode  (zero_b),
        .btn_set   (zero_b),
        .hours     (hours_b),
        .minutes   (minutes_b),
        .seconds   (seconds_b),
        .mode      (mode_b),
        .blink     (blink_b),
        .sec_pulse (sec_pulse_b)
    );

    function automatic vec_t mk(input logic t, input logic bm, input logic bs,
                                input int h, input int m, input int s,
                                input int md, input logic bl, input logic sp);
        vec_t v;
        v.tick = t;  v.bm = bm;  v.bs = bs;
        v.h  = 5'(h);  v.m = 6'(m);  v.s = 6'(s);
        v.md = 2'(md); v.bl = bl;    v.sp = sp;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int h, input int m, input int s,
                           input int md, input int bl, input int sp);
        chk({tag, " hours"},     int'(hours),     h);
        chk({tag, " minutes"},   int'(minutes),   m);
        chk({tag, " seconds"},   int'(seconds),   s);
        chk({tag, " mode"},      int'(mode),      md);
        chk({tag, " blink"},     int'(blink),     bl);
        chk({tag, " sec_pulse"}, int'(sec_pulse), sp);
    endtask

    // Called at a negedge: drive inputs, return at the next negedge so the
    // outputs reflect the posedge that sampled these inputs.
    task automatic apply(input logic t, input logic bm, input logic bs);
        tick  = t;
        bmode = bm;
        bset  = bs;
        @(negedge clk);
    endtask

    // Leaves one idle cycle after release so the tick edge detector is armed.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        tick = 1'b0; bmode = 1'b0; bset = 1'b0; tick_b = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic edges(input int n);
        for (int i = 0; i < n; i++) begin
            apply(1'b1, 1'b0, 1'b0);
            apply(1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic presses(input logic bm, input logic bs, input int n);
        for (int i = 0; i < n; i++) apply(1'b0, bm, bs);
        apply(1'b0, 1'b0, 1'b0);
    endtask

    vec_t vecs[13];

    initial begin
        vecs[0]  = mk(1, 0, 0, 0, 0, 1, 0, 1, 1);
        vecs[1]  = mk(0, 0, 0, 0, 0, 1, 0, 1, 0);
        vecs[2]  = mk(1, 0, 0, 0, 0, 2, 0, 1, 1);
        vecs[3]  = mk(0, 1, 0, 0, 0, 2, 1, 1, 0);
        vecs[4]  = mk(0, 0, 1, 1, 0, 2, 1, 1, 0);
        vecs[5]  = mk(1, 0, 0, 1, 0, 2, 1, 0, 0);
        vecs[6]  = mk(0, 0, 0, 1, 0, 2, 1, 0, 0);
        vecs[7]  = mk(1, 0, 0, 1, 0, 2, 1, 1, 0);
        vecs[8]  = mk(0, 1, 1, 1, 0, 2, 2, 1, 0);
        vecs[9]  = mk(0, 0, 1, 1, 1, 2, 2, 1, 0);
        vecs[10] = mk(0, 1, 0, 1, 1, 0, 0, 1, 0);
        vecs[11] = mk(1, 0, 0, 1, 1, 1, 0, 1, 1);
        vecs[12] = mk(0, 0, 0, 1, 1, 1, 0, 1, 0);

        // Reset state
        do_reset();
        chk_all("reset", 0, 0, 0, 0, 1, 0);

        // Vector table
        for (int i = 0; i < 13; i++) begin
            apply(vecs[i].tick, vecs[i].bm, vecs[i].bs);
            chk_all($sformatf("vec%0d", i), vecs[i].h, vecs[i].m, vecs[i].s,
                    vecs[i].md, vecs[i].bl, vecs[i].sp);
        end

        // Set flow with field wraps and no cross-field carry
        do_reset();
        presses(1'b1, 1'b0, 1);
        presses(1'b0, 1'b1, 25);
        chk("setflow hours", int'(hours), 1);
        presses(1'b1, 1'b0, 1);
        presses(1'b0, 1'b1, 61);
        chk_all("setflow min", 1, 1, 0, 2, 1, 0);
        presses(1'b1, 1'b0, 1);
        chk_all("setflow exit", 1, 1, 0, 0, 1, 0);

        // Tick edge on RUN -> SET_HR still increments
        apply(1'b1, 1'b1, 1'b0);
        chk_all("run2sethr tick", 1, 1, 1, 1, 1, 1);
        apply(1'b0, 1'b0, 1'b0);
        apply(1'b0, 1'b1, 1'b0);
        // Tick edge on SET_MIN -> RUN is lost to the seconds clear
        apply(1'b1, 1'b1, 1'b0);
        chk_all("setmin2run tick", 1, 1, 0, 0, 1, 0);
        apply(1'b0, 1'b0, 1'b0);

        // Rollover 23:59:58 -> 23:59:59 -> 00:00:00
        do_reset();
        presses(1'b1, 1'b0, 1);
        presses(1'b0, 1'b1, 23);
        presses(1'b1, 1'b0, 1);
        presses(1'b0, 1'b1, 59);
        presses(1'b1, 1'b0, 1);
        edges(58);
        chk_all("roll 58", 23, 59, 58, 0, 1, 0);
        apply(1'b1, 1'b0, 1'b0);
        chk_all("roll 59", 23, 59, 59, 0, 1, 1);
        apply(1'b0, 1'b0, 1'b0);
        chk("roll 59 pulse low", int'(sec_pulse), 0);
        apply(1'b1, 1'b0, 1'b0);
        chk_all("roll 00", 0, 0, 0, 0, 1, 1);
        apply(1'b0, 1'b0, 1'b0);
        chk("roll 00 pulse low", int'(sec_pulse), 0);

        // tick_in held high through reset release
        @(negedge clk);
        rst_n = 1'b0;
        tick  = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) apply(1'b1, 1'b0, 1'b0);
        chk("tickhigh no inc", int'(seconds), 0);
        apply(1'b0, 1'b0, 1'b0);
        apply(1'b1, 1'b0, 1'b0);
        chk("tickhigh rearm", int'(seconds), 1);
        apply(1'b0, 1'b0, 1'b0);

        // Asynchronous reset in the middle of SET_MIN editing
        presses(1'b1, 1'b0, 2);
        presses(1'b0, 1'b1, 3);
        chk_all("pre async", 0, 3, 1, 2, 1, 0);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 chk_all("async rst", 0, 0, 0, 0, 1, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);

        // TICKS_PER_SEC = 4 instance
        for (int i = 0; i < 7; i++) begin
            tick_b = 1'b1; @(negedge clk);
            tick_b = 1'b0; @(negedge clk);
        end
        chk("presc4 seconds", int'(seconds_b), 1);
        chk("presc4 count",   int'(dut_b.presc_q), 3);
        tick_b = 1'b1; @(negedge clk);
        chk("presc4 8th seconds", int'(seconds_b), 2);
        chk("presc4 8th pulse",   int'(sec_pulse_b), 1);
        tick_b = 1'b0; @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

endmodule : tb_watch_timekeeper
`default_nettype wire
